serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial N-bit adder built around the team's 1-bit fulladder cell.
- Accepts two N-bit operands plus a carry-in through a valid/ready handshake.
- Feeds one bit pair per cycle, LSB first, through a single fulladder instance, with the carry held in a flop.
- Presents the N-bit sum and carry-out through a valid/ready handshake.
- Trades latency for area, for datapaths where a ripple chain is too large.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  initial carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  A+B+cin, modulo 2^WIDTH
- out_cout  output  1  final carry-out

Behaviour:
- One clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_sum=0, out_cout=0.
  - Carry flop=0, bit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a and in_b into shift registers and in_cin into the carry flop.
  - Clear the counter and the sum register, then go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the fulladder sees A=a_sr[0], B=b_sr[0], Cin=carry flop.
  - Its S output shifts into the MSB of the sum shift register; its Co output loads the carry flop.
  - a_sr and b_sr shift right one bit; the counter increments.
  - When the counter reaches WIDTH-1, the last bit is processed in that cycle and the FSM goes to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - On out_valid&&out_ready, go to IDLE next cycle.
  - No combinational path from out_ready to in_ready.
- Latency: handshake accepted in cycle 0 → out_valid asserted in cycle WIDTH+1. Throughput is one addition per WIDTH+2 cycles minimum.
- Counter width is $clog2(WIDTH). Arithmetic is unsigned and modulo 2^WIDTH; the carry out of the MSB goes to out_cout.
- Boundary conditions:
  - Operands are captured at acceptance. Changes on in_a, in_b or in_cin after acceptance are ignored.
  - in_valid during RUN or DONE is ignored and no data is lost; the upstream must hold until in_ready.
  - Backpressure: out_valid stays high and the outputs stay stable indefinitely while out_ready=0.
  - rst mid-RUN or mid-DONE aborts the operation: the partial result is discarded and all reset values apply on the next edge.
  - The output register is not cleared by consumption; only a new acceptance clears it.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), the two's-complement signed overflow flag.
  - out_ovf = carry into MSB XOR carry out of MSB, registered at the final RUN cycle.
  - Valid with out_valid; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum typedef {IDLE, RUN, DONE} with 2-bit encoding;
  - localparam WIDTH_DEFAULT=8;
  - a constant function for the counter width.
- One sub-module instance: the existing fulladder cell, single instance, ports A, B, Cin, S, Co.
- No other hierarchy.

Test Plan:
- WIDTH=8, a=0x3C, b=0x05, cin=0, out_ready=1 → out_sum=0x41, out_cout=0, out_valid rises exactly 9 cycles after acceptance.
- a=0xFF, b=0x01, cin=0 → out_sum=0x00, out_cout=1. With SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 → out_sum=0x80, out_ovf=1.
- a=0xFF, b=0xFF, cin=1 → out_sum=0xFF, out_cout=1. Check that in_a changing during RUN does not alter the result.
- Hold out_ready=0 for 20 cycles after out_valid → out_sum and out_cout stable, in_ready=0 throughout. Release → out_valid drops next cycle, in_ready=1.
- Assert rst at RUN cycle 4 → next edge: out_valid=0, in_ready=1, out_sum=0. A new add of 0x10+0x20 then gives 0x30 with no residue from the aborted carry.
- Back-to-back: in_valid held high with 50 random operand pairs → every result matches a reference model of (a+b+cin), and each acceptance is spaced at least WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Bit-counter width; a 1-bit floor keeps the counter a legal vector.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fulladder.sv
// 1-bit full adder cell.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Cin;
  assign Co = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder, LSB first, valid/ready on both sides.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag out_ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             fa_s, fa_co;
  logic             ovf_q;

  fulladder u_fa (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .Cin(carry_q),
    .S  (fa_s),
    .Co (fa_co)
  );

  // The sum shift register is the output register: after WIDTH shifts it holds the result.
  assign out_sum = sum_sr;

`ifdef SERIAL_ADDER_OVF_EN
  assign out_ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      out_cout  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            carry_q  <= in_cin;
            cnt      <= '0;
            sum_sr   <= '0;
            out_cout <= 1'b0;
            ovf_q    <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry_q here is the carry into the MSB, fa_co the carry out of it.
            out_cout  <= fa_co;
            ovf_q     <= carry_q ^ fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef SERIAL_ADDER_OVF_EN
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner sequences, random back-to-back.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout", name);
  endtask

  // Starts and ends at a negedge; on return the acceptance edge has just passed.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) fail_now("send_wait");
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(in_ready), 64'(0));
  endtask

  // Scrambles inputs with in_valid high while busy; lat is cycles from acceptance to out_valid.
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!out_valid && n < 60) begin
      in_valid = 1'b1;
      in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) fail_now("wait_valid");
    lat = n + 1;
  endtask

  initial begin
    int lat;
    tbl[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_cout", 64'(out_cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // Vector table, consumer always ready
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_valid(lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(W + 1));
      chk($sformatf("tbl%0d_sum", i), 64'(out_sum), 64'(tbl[i].s));
      chk($sformatf("tbl%0d_cout", i), 64'(out_cout), 64'(tbl[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 64'(out_ovf), 64'(tbl[i].ov));
`endif
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_drop", i), 64'(out_valid), 64'(0));
      chk($sformatf("tbl%0d_ready_back", i), 64'(in_ready), 64'(1));
    end

    // Backpressure: result must sit still for 20 cycles
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_sum", 64'(out_sum), 64'(8'h47));
      chk("bp_cout", 64'(out_cout), 64'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'(0));
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    chk("bp_sum_kept", 64'(out_sum), 64'(8'h47));

    // Reset mid-RUN, then a clean add with no leftover carry
    send(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_ready", 64'(in_ready), 64'(1));
    chk("abort_sum", 64'(out_sum), 64'(0));
    chk("abort_cout", 64'(out_cout), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    send(8'h10, 8'h20, 1'b0);
    wait_valid(lat);
    chk("post_abort_sum", 64'(out_sum), 64'(8'h30));
    chk("post_abort_cout", 64'(out_cout), 64'(0));
    @(negedge clk);

    // Random back-to-back with in_valid held high
    begin
      logic [9:0] expq[$];
      logic [9:0] e;
      int sent = 0, got = 0, k = 0, last = -1000, sa, sb, tot;
      bit pending = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
      in_valid = 1'b1;
      while (got < 50 && k < 5000) begin
        if (pending) begin
          in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
          pending = 1'b0;
          if (sent == 50) in_valid = 1'b0;
        end
        if (out_valid) begin
          if (expq.size() == 0) fail_now("rand_unexpected_result");
          else begin
            e = expq.pop_front();
            chk("rand_sum", 64'(out_sum), 64'(e[7:0]));
            chk("rand_cout", 64'(out_cout), 64'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
            chk("rand_ovf", 64'(out_ovf), 64'(e[9]));
`endif
          end
          got++;
        end
        if (in_ready && in_valid) begin
          sa  = $signed(in_a);
          sb  = $signed(in_b);
          tot = int'(in_a) + int'(in_b) + int'(in_cin);
          e[7:0] = 8'(tot);
          e[8]   = (tot > 255);
          e[9]   = (sa + sb + int'(in_cin) > 127) || (sa + sb + int'(in_cin) < -128);
          expq.push_back(e);
          if (last > -1000) chk("rand_spacing_ok", 64'(k - last >= W + 2), 64'(1));
          last = k;
          sent++;
          pending = 1'b1;
        end
        @(negedge clk);
        k++;
      end
      in_valid = 1'b0;
      if (got < 50) fail_now("rand_results");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
